// File: rtl/channel_serializer.sv
// Splits each N-bit word into K chunks of W bits, least-significant chunk first.
// The final chunk of a word carries a set flag in out_d_o[W].
module channel_serializer #(
  parameter int N = 32,
  parameter int K = 4,
  parameter int W = N / K
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in_d_i,
  input  logic         in_v_i,
  output logic         in_a_o,
  output logic [W:0]   out_d_o,
  output logic         out_v_o,
  input  logic         out_a_i
);

  localparam int IW = $clog2(K);
  localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

  generate
    if ((N % K != 0) || (K < 2)) begin : g_bad_params
      $error("channel_serializer: N must be a multiple of K and K must be at least 2");
    end
  endgenerate

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  buf_q, buf_d;
  logic          last_s;

  assign last_s  = (idx_q == LAST_IDX);
  assign out_v_o = (state_q == S_SEND);
  assign out_d_o = {last_s, buf_q[idx_q*W +: W]};
  // Accept a word whenever the slot is free or is freed by this cycle's final ack.
  assign in_a_o  = in_v_i & ((state_q == S_IDLE) | (out_v_o & out_a_i & last_s));

  // State, chunk index and word buffer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state logic; the buffer only reloads on an accepted word.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    case (state_q)
      S_IDLE: begin
        if (in_v_i) begin
          buf_d   = in_d_i;
          idx_d   = '0;
          state_d = S_SEND;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (!out_a_i) begin
          state_d = S_SEND;
        end else if (!last_s) begin
          idx_d = idx_q + IW'(1);
        end else if (in_v_i) begin
          buf_d = in_d_i;
          idx_d = '0;
        end else begin
          idx_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_channel_serializer.sv
// Directed and randomised checks of channel_serializer with N=16, K=4.
module tb_channel_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] in_d = 16'h0000;
  logic        in_v = 1'b0;
  logic        in_a;
  logic [4:0]  out_d;
  logic        out_v;
  logic        out_a = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  channel_serializer #(.N(16), .K(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_d_i  (in_d),
    .in_v_i  (in_v),
    .in_a_o  (in_a),
    .out_d_o (out_d),
    .out_v_o (out_v),
    .out_a_i (out_a)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [15:0] id, input logic oa);
    @(negedge clk);
    in_v  = iv;
    in_d  = id;
    out_a = oa;
    #1;
  endtask

  task automatic expect_chunk(input string tag, input logic [4:0] d, input logic a);
    chk({tag, ".v"}, {31'd0, out_v}, 32'd1);
    chk({tag, ".d"}, {27'd0, out_d}, {27'd0, d});
    chk({tag, ".a"}, {31'd0, in_a}, {31'd0, a});
  endtask

  task automatic expect_idle(input string tag, input logic a);
    chk({tag, ".v"}, {31'd0, out_v}, 32'd0);
    chk({tag, ".a"}, {31'd0, in_a}, {31'd0, a});
  endtask

  logic [15:0] expq[$];
  logic [15:0] asm_word;
  logic [15:0] src_d;
  logic [15:0] want_word;
  logic [4:0]  prev_d;
  logic        src_v;
  logic        prev_stall;
  int          ccount;
  int          words_sent;
  int          words_out;

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst.v", {31'd0, out_v}, 32'd0);
    chk("rst.d", {27'd0, out_d}, 32'd0);
    chk("rst.a", {31'd0, in_a}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // single word
    drive(1'b1, 16'hABCD, 1'b1); expect_idle("sw.acc", 1'b1);
    drive(1'b0, 16'h0000, 1'b1); expect_chunk("sw.c0", 5'h0D, 1'b0);
    drive(1'b0, 16'h0000, 1'b1); expect_chunk("sw.c1", 5'h0C, 1'b0);
    drive(1'b0, 16'h0000, 1'b1); expect_chunk("sw.c2", 5'h0B, 1'b0);
    drive(1'b0, 16'h0000, 1'b1); expect_chunk("sw.c3", 5'h1A, 1'b0);
    drive(1'b0, 16'h0000, 1'b1); expect_idle("sw.end", 1'b0);

    // back-to-back words with no bubble
    drive(1'b1, 16'h1234, 1'b1); expect_idle("bb.acc", 1'b1);
    drive(1'b1, 16'h5678, 1'b1); expect_chunk("bb.c0", 5'h04, 1'b0);
    drive(1'b1, 16'h5678, 1'b1); expect_chunk("bb.c1", 5'h03, 1'b0);
    drive(1'b1, 16'h5678, 1'b1); expect_chunk("bb.c2", 5'h02, 1'b0);
    drive(1'b1, 16'h5678, 1'b1); expect_chunk("bb.c3", 5'h11, 1'b1);
    drive(1'b0, 16'h0000, 1'b1); expect_chunk("bb.c4", 5'h08, 1'b0);
    drive(1'b0, 16'h0000, 1'b1); expect_chunk("bb.c5", 5'h07, 1'b0);
    drive(1'b0, 16'h0000, 1'b1); expect_chunk("bb.c6", 5'h06, 1'b0);
    drive(1'b0, 16'h0000, 1'b1); expect_chunk("bb.c7", 5'h15, 1'b0);
    drive(1'b0, 16'h0000, 1'b1); expect_idle("bb.end", 1'b0);

    // backpressure on chunk 1 with a second word waiting
    drive(1'b1, 16'hABCD, 1'b1); expect_idle("bp.acc", 1'b1);
    drive(1'b1, 16'h1234, 1'b1); expect_chunk("bp.c0", 5'h0D, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h1234, 1'b0); expect_chunk($sformatf("bp.hold%0d", i), 5'h0C, 1'b0);
    end
    drive(1'b1, 16'h1234, 1'b1); expect_chunk("bp.c1", 5'h0C, 1'b0);
    drive(1'b1, 16'h1234, 1'b1); expect_chunk("bp.c2", 5'h0B, 1'b0);
    drive(1'b1, 16'h1234, 1'b1); expect_chunk("bp.c3", 5'h1A, 1'b1);
    drive(1'b0, 16'h0000, 1'b1); expect_chunk("bp.n0", 5'h04, 1'b0);
    drive(1'b0, 16'h0000, 1'b1); expect_chunk("bp.n1", 5'h03, 1'b0);
    drive(1'b0, 16'h0000, 1'b1); expect_chunk("bp.n2", 5'h02, 1'b0);
    drive(1'b0, 16'h0000, 1'b1); expect_chunk("bp.n3", 5'h11, 1'b0);
    drive(1'b0, 16'h0000, 1'b1); expect_idle("bp.end", 1'b0);

    // reset in the middle of a word
    drive(1'b1, 16'hABCD, 1'b1); expect_idle("rm.acc", 1'b1);
    drive(1'b0, 16'h0000, 1'b1); expect_chunk("rm.c0", 5'h0D, 1'b0);
    drive(1'b0, 16'h0000, 1'b1); expect_chunk("rm.c1", 5'h0C, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rm.rst.v", {31'd0, out_v}, 32'd0);
    chk("rm.rst.d", {27'd0, out_d}, 32'd0);
    chk("rm.rst.a", {31'd0, in_a}, 32'd0);
    drive(1'b0, 16'h0000, 1'b1);
    chk("rm.rst2.v", {31'd0, out_v}, 32'd0);
    chk("rm.rst2.d", {27'd0, out_d}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    in_v  = 1'b1;
    in_d  = 16'h00FF;
    out_a = 1'b1;
    #1;
    expect_idle("rm.acc2", 1'b1);
    drive(1'b0, 16'h0000, 1'b1); expect_chunk("rm.n0", 5'h0F, 1'b0);
    drive(1'b0, 16'h0000, 1'b1); expect_chunk("rm.n1", 5'h0F, 1'b0);
    drive(1'b0, 16'h0000, 1'b1); expect_chunk("rm.n2", 5'h00, 1'b0);
    drive(1'b0, 16'h0000, 1'b1); expect_chunk("rm.n3", 5'h10, 1'b0);
    drive(1'b0, 16'h0000, 1'b1); expect_idle("rm.end", 1'b0);

    // random soak: random source gaps and sink stalls, 1000 words
    src_v      = 1'b0;
    src_d      = 16'h0000;
    prev_stall = 1'b0;
    prev_d     = 5'h00;
    asm_word   = 16'h0000;
    ccount     = 0;
    words_sent = 0;
    words_out  = 0;
    for (int cyc = 0; cyc < 40000 && words_out < 1000; cyc++) begin
      @(negedge clk);
      if (!src_v && words_sent < 1000 && $urandom_range(3, 0) != 0) begin
        src_v = 1'b1;
        src_d = 16'($urandom);
      end
      in_v  = src_v;
      in_d  = src_d;
      out_a = ($urandom_range(3, 0) != 0);
      #1;
      if (prev_stall) begin
        chk("soak.hold_v", {31'd0, out_v}, 32'd1);
        chk("soak.hold_d", {27'd0, out_d}, {27'd0, prev_d});
      end
      if (!in_v) chk("soak.a_no_v", {31'd0, in_a}, 32'd0);
      if (in_v && in_a) begin
        expq.push_back(in_d);
        src_v = 1'b0;
        words_sent++;
      end
      if (out_v && out_a) begin
        asm_word[ccount*4 +: 4] = out_d[3:0];
        chk("soak.last", {31'd0, out_d[4]}, (ccount == 3) ? 32'd1 : 32'd0);
        if (ccount == 3) begin
          want_word = (expq.size() > 0) ? expq.pop_front() : 16'hXXXX;
          chk("soak.word", {16'd0, asm_word}, {16'd0, want_word});
          ccount = 0;
          words_out++;
        end else begin
          ccount++;
        end
      end
      prev_stall = out_v && !out_a;
      prev_d     = out_d;
    end
    chk("soak.count", words_out, 32'd1000);
    chk("soak.leftover", expq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
